// File: rtl/uesprit_pkg.sv
// -----------------------------------------------------------------------------
// uesprit_pkg
// Shared definitions for the uESPRIT accumulation scheduler: scheduler state
// encoding and the default number of channels per frame.
// -----------------------------------------------------------------------------
package uesprit_pkg;

    // Default channels per frame (power of two, at least 2).
    localparam int VECTOR_LEN_DEFAULT = 64;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

endpackage

// File: rtl/uesprit_acc_scheduler_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-N counter with synchronous clear and increment enable.
// The clear is applied before the increment in the same cycle, so an
// increment coincident with a clear counts from 0 (the restart sample is
// itself counted and the counter lands on 1).
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset, count -> 0
//   clear_i  restart the count from 0 this cycle
//   inc_i    advance the count by one (modulo N)
//   count_o  current count
//   wrap_o   combinational: this cycle's increment takes the count N-1 -> 0
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] base;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        base    = clear_i ? '0 : count_q;
        wrap_o  = inc_i && (base == W'(N - 1));
        count_d = base;
        if (inc_i) begin
            count_d = wrap_o ? '0 : base + W'(1);
        end
    end

    // NOTE: clocked state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uesprit_acc_scheduler.sv
// -----------------------------------------------------------------------------
// uesprit_acc_scheduler
// Frame/accumulation scheduler for the uESPRIT correlation datapath. Tracks
// the channel and frame position of incoming samples, issues a one-cycle
// accumulation-restart pulse aligned with the datapath input register, flags
// misaligned frame syncs, and counts dumped correlation vectors.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          scheduler enable; low forces IDLE
//   acc_len     frames per accumulation (0 behaves as 1)
//   sync_in     frame-start marker, coincident with the channel 0 sample
//   din_valid   input sample strobe
//   new_acc     registered accumulation-restart pulse (1-cycle latency)
//   chan_idx    registered channel index of the previously accepted sample
//   corr_valid  correlation-result strobe from the datapath
//   out_last    registered marker of the last channel of a dumped vector
//   dump_cnt    saturating count of completed dumps
//   err_sync    sticky misaligned-sync flag, cleared on re-enable
//   busy        registered "state is not IDLE"
// -----------------------------------------------------------------------------
module uesprit_acc_scheduler
    import uesprit_pkg::*;
#(
    parameter int VECTOR_LEN     = VECTOR_LEN_DEFAULT,
    parameter int ACC_LEN_WIDTH  = 16,
    parameter int DUMP_CNT_WIDTH = 32,
    localparam int CW            = $clog2(VECTOR_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [ACC_LEN_WIDTH-1:0]  acc_len,
    input  logic                      sync_in,
    input  logic                      din_valid,
    output logic                      new_acc,
    output logic [CW-1:0]             chan_idx,
    input  logic                      corr_valid,
    output logic                      out_last,
    output logic [DUMP_CNT_WIDTH-1:0] dump_cnt,
    output logic                      err_sync,
    output logic                      busy
);

    state_e state_q;
    state_e state_d;

    // FSM decodes
    logic accept;      // sample counted this cycle
    logic start;       // first sample of a run (WAIT_SYNC -> RUN)
    logic resync;      // sync seen in RUN away from channel 0
    logic err_clear;   // re-enable from IDLE
    logic chan_clear;  // restart channel/frame position
    logic busy_d;

    logic [CW-1:0]            chan_cnt;
    logic [CW-1:0]            chan_base;
    logic                     chan_wrap;
    logic [CW-1:0]            out_chan;
    logic                     out_wrap;

    logic [ACC_LEN_WIDTH-1:0] frame_q, frame_d, frame_base;
    logic [ACC_LEN_WIDTH-1:0] len_q, len_d;
    logic [ACC_LEN_WIDTH-1:0] eff_acc_len;
    logic                     new_acc_d;

    logic                      new_acc_q;
    logic [CW-1:0]             chan_idx_q;
    logic                      err_sync_q;
    logic                      busy_q;
    logic                      out_last_q;
    logic [DUMP_CNT_WIDTH-1:0] dump_cnt_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_SYNC;
                ST_WAIT_SYNC: if (sync_in && din_valid) state_d = ST_RUN;
                ST_RUN:       state_d = ST_RUN;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept    = 1'b0;
        start     = 1'b0;
        resync    = 1'b0;
        err_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_clear = en;
            end
            ST_WAIT_SYNC: begin
                start  = en && sync_in && din_valid;
                accept = start;
            end
            ST_RUN: begin
                accept = en && din_valid;
                resync = accept && sync_in && (chan_cnt != '0);
            end
            default: ;
        endcase
        // Position is held at 0 outside RUN and while disabled, so the
        // counters are already clean when a run starts.
        chan_clear = !en || (state_q != ST_RUN) || resync;
        busy_d     = (state_d != ST_IDLE);
    end

    // ------------------------------------------------- channel / frame position
    wrap_counter #(
        .N (VECTOR_LEN),
        .W (CW)
    ) u_chan_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (chan_clear),
        .inc_i   (accept),
        .count_o (chan_cnt),
        .wrap_o  (chan_wrap)
    );

    assign chan_base   = chan_clear ? '0 : chan_cnt;
    assign frame_base  = chan_clear ? '0 : frame_q;
    assign eff_acc_len = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;

    always_comb begin
        frame_d = frame_base;
        len_d   = len_q;
        if (start || resync) begin
            len_d = eff_acc_len;
        end
        if (chan_wrap) begin
            // End of the last frame of an accumulation: the length for the
            // next accumulation is taken at this boundary only.
            if (frame_base == len_q - ACC_LEN_WIDTH'(1)) begin
                frame_d = '0;
                len_d   = eff_acc_len;
            end else begin
                frame_d = frame_base + ACC_LEN_WIDTH'(1);
            end
        end
        // Channel 0 of frame 0 opens an accumulation.
        new_acc_d = accept && (chan_base == '0) && (frame_base == '0);
    end

    // ---------------------------------------------------------- output side
    wrap_counter #(
        .N (VECTOR_LEN),
        .W (CW)
    ) u_out_chan (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .inc_i   (corr_valid),
        .count_o (out_chan),
        .wrap_o  (out_wrap)
    );

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= '0;
            len_q      <= ACC_LEN_WIDTH'(1);
            new_acc_q  <= 1'b0;
            chan_idx_q <= '0;
            err_sync_q <= 1'b0;
            busy_q     <= 1'b0;
            out_last_q <= 1'b0;
            dump_cnt_q <= '0;
        end else begin
            frame_q   <= frame_d;
            len_q     <= len_d;
            new_acc_q <= new_acc_d;
            busy_q    <= busy_d;
            if (accept) begin
                chan_idx_q <= chan_base;
            end
            if (err_clear) begin
                err_sync_q <= 1'b0;
            end else if (resync) begin
                err_sync_q <= 1'b1;
            end
            out_last_q <= out_wrap;
            if (out_wrap && (dump_cnt_q != '1)) begin
                dump_cnt_q <= dump_cnt_q + DUMP_CNT_WIDTH'(1);
            end
        end
    end

    assign new_acc  = new_acc_q;
    assign chan_idx = chan_idx_q;
    assign err_sync = err_sync_q;
    assign busy     = busy_q;
    assign out_last = out_last_q;
    assign dump_cnt = dump_cnt_q;

endmodule

// File: tb/tb_uesprit_acc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uesprit_acc_scheduler
// Directed bench for uesprit_acc_scheduler with VECTOR_LEN = 4. Stimulus code
// pushes hand-computed expectations (cycle of each new_acc / out_last pulse,
// and level values of chan_idx, busy, err_sync, dump_cnt at given cycles);
// a monitor on the falling edge pops and compares them against the DUT.
// An input presented during cycle N shows its registered response at N+1.
// -----------------------------------------------------------------------------
module tb_uesprit_acc_scheduler;

    localparam int VL = 4;
    localparam int K_CHAN = 0;
    localparam int K_BUSY = 1;
    localparam int K_ERR  = 2;
    localparam int K_DUMP = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] acc_len = '0;
    logic        sync_in = 1'b0;
    logic        din_valid = 1'b0;
    logic        corr_valid = 1'b0;
    logic        new_acc;
    logic [1:0]  chan_idx;
    logic        out_last;
    logic [31:0] dump_cnt;
    logic        err_sync;
    logic        busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   newacc_q[$];
    int   last_q[$];
    exp_t lvl_q[$];

    uesprit_acc_scheduler #(
        .VECTOR_LEN     (VL),
        .ACC_LEN_WIDTH  (16),
        .DUMP_CNT_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .acc_len    (acc_len),
        .sync_in    (sync_in),
        .din_valid  (din_valid),
        .new_acc    (new_acc),
        .chan_idx   (chan_idx),
        .corr_valid (corr_valid),
        .out_last   (out_last),
        .dump_cnt   (dump_cnt),
        .err_sync   (err_sync),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic s, input logic v, input logic c);
        en         = e;
        sync_in    = s;
        din_valid  = v;
        corr_valid = c;
        tick();
    endtask

    task automatic push_lvl(input int c, input int k, input int v);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.val  = v;
        lvl_q.push_back(x);
    endtask

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        int   e;
        exp_t x;
        while (newacc_q.size() > 0 && newacc_q[0] < cyc) begin
            check("new_acc_missing", 0, 1);
            e = newacc_q.pop_front();
        end
        while (last_q.size() > 0 && last_q[0] < cyc) begin
            check("out_last_missing", 0, 1);
            e = last_q.pop_front();
        end
        if (new_acc === 1'b1) begin
            if (newacc_q.size() == 0) begin
                check("new_acc_unexpected", cyc, -1);
            end else begin
                e = newacc_q.pop_front();
                check("new_acc_cycle", cyc, e);
            end
        end
        if (out_last === 1'b1) begin
            if (last_q.size() == 0) begin
                check("out_last_unexpected", cyc, -1);
            end else begin
                e = last_q.pop_front();
                check("out_last_cycle", cyc, e);
            end
        end
        for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].cyc <= cyc) begin
                x = lvl_q[i];
                case (x.kind)
                    K_CHAN:  check("chan_idx", chan_idx, x.val);
                    K_BUSY:  check("busy", busy, x.val);
                    K_ERR:   check("err_sync", err_sync, x.val);
                    default: check("dump_cnt", dump_cnt, x.val);
                endcase
                lvl_q.delete(i);
            end
        end
    end

    // ------------------------------------------------------------ watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int t0;
        int t;
        int c;

        // Reset state
        tick();
        tick();
        push_lvl(cyc, K_CHAN, 0);
        push_lvl(cyc, K_BUSY, 0);
        push_lvl(cyc, K_ERR, 0);
        push_lvl(cyc, K_DUMP, 0);
        rst = 1'b0;

        // acc_len = 3, continuous samples; sync at channel 0 mid-run is a
        // no-op; acc_len change only takes effect at an accumulation boundary.
        acc_len = 16'd3;
        c = cyc;
        drive(1, 0, 0, 0);               // IDLE -> WAIT_SYNC
        push_lvl(c + 1, K_BUSY, 1);
        drive(1, 0, 1, 0);               // valid without sync: ignored
        drive(1, 1, 0, 0);               // sync without valid: ignored
        t0 = cyc;
        newacc_q.push_back(t0 + 1);
        newacc_q.push_back(t0 + 13);
        newacc_q.push_back(t0 + 25);
        newacc_q.push_back(t0 + 29);     // acc_len 1 from sample 24 on
        push_lvl(t0 + 5, K_ERR, 0);
        push_lvl(t0 + 10, K_BUSY, 1);
        for (int k = 0; k < 30; k++) begin
            if (k < 8) push_lvl(t0 + k + 1, K_CHAN, k % VL);
            if (k == 15) acc_len = 16'd1;
            drive(1, (k == 0) || (k == 4), 1, 0);
        end

        // en dropped mid-accumulation; no pulse until a new sync.
        c = cyc;
        drive(0, 0, 1, 0);
        push_lvl(c + 1, K_BUSY, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);               // -> WAIT_SYNC
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);

        // acc_len = 0 behaves as 1: new_acc every 4 samples.
        acc_len = 16'd0;
        t0 = cyc;
        newacc_q.push_back(t0 + 1);
        newacc_q.push_back(t0 + 5);
        newacc_q.push_back(t0 + 9);
        for (int k = 0; k < 12; k++) drive(1, k == 0, 1, 0);

        // Misaligned sync at channel 2.
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        acc_len = 16'd3;
        t0 = cyc;
        newacc_q.push_back(t0 + 1);
        newacc_q.push_back(t0 + 7);
        newacc_q.push_back(t0 + 19);
        push_lvl(t0 + 6, K_CHAN, 1);
        push_lvl(t0 + 6, K_ERR, 0);
        push_lvl(t0 + 7, K_CHAN, 0);
        push_lvl(t0 + 7, K_ERR, 1);
        push_lvl(t0 + 8, K_CHAN, 1);
        push_lvl(t0 + 20, K_ERR, 1);
        for (int k = 0; k < 20; k++) drive(1, (k == 0) || (k == 6), 1, 0);
        c = cyc;
        drive(0, 0, 0, 0);
        push_lvl(c + 1, K_ERR, 1);       // still set while disabled
        c = cyc;
        drive(1, 0, 0, 0);
        push_lvl(c + 1, K_ERR, 0);       // cleared on re-enable

        // Gapped samples (1 of 3 cycles), acc_len = 2: pulse every 8 samples.
        acc_len = 16'd2;
        t0 = cyc;
        newacc_q.push_back(t0 + 1);
        newacc_q.push_back(t0 + 25);
        newacc_q.push_back(t0 + 49);
        push_lvl(t0 + 8, K_CHAN, 2);
        push_lvl(t0 + 11, K_CHAN, 3);
        for (int k = 0; k < 20; k++) begin
            drive(1, k == 0, 1, 0);
            drive(1, 0, 0, 0);
            drive(1, 0, 0, 0);
        end
        drive(0, 0, 0, 0);

        // 12 correlation results -> 3 dumps.
        for (int i = 0; i < 12; i++) begin
            t = cyc;
            if (i % VL == VL - 1) last_q.push_back(t + 1);
            if (i == 7) push_lvl(t + 2, K_DUMP, 2);
            if (i == 11) push_lvl(t + 2, K_DUMP, 3);
            drive(0, 0, 0, 1);
            drive(0, 0, 0, 0);
        end

        // Reset in the middle of a run (with err_sync set).
        drive(1, 0, 0, 0);
        acc_len = 16'd3;
        t0 = cyc;
        newacc_q.push_back(t0 + 1);
        newacc_q.push_back(t0 + 3);
        push_lvl(t0 + 3, K_ERR, 1);
        push_lvl(t0 + 4, K_CHAN, 1);
        drive(1, 1, 1, 1);
        drive(1, 0, 1, 1);
        drive(1, 1, 1, 0);
        drive(1, 0, 1, 0);
        c = cyc;
        rst = 1'b1;
        drive(1, 0, 1, 1);
        push_lvl(c + 1, K_CHAN, 0);
        push_lvl(c + 1, K_BUSY, 0);
        push_lvl(c + 1, K_ERR, 0);
        push_lvl(c + 1, K_DUMP, 0);
        rst = 1'b0;
        drive(1, 0, 1, 0);               // IDLE -> WAIT_SYNC
        push_lvl(c + 2, K_BUSY, 1);
        drive(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            if (i == 3) begin
                last_q.push_back(t + 1);
                push_lvl(t + 2, K_DUMP, 1);
            end
            drive(1, 0, 0, 1);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        foreach (newacc_q[i]) check("new_acc_never_seen", 0, 1);
        foreach (last_q[i]) check("out_last_never_seen", 0, 1);
        foreach (lvl_q[i]) check("level_never_checked", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uesprit_acc_scheduler.md
UESPRIT_ACC_SCHEDULER -- requirements
Module: uesprit_acc_scheduler

Interface
REQ-001 SHALL have parameter VECTOR_LEN, default 64, channels per frame (power of 2, >=2).
REQ-002 SHALL have parameter ACC_LEN_WIDTH, default 16, width of the accumulation-length configuration.
REQ-003 SHALL have parameter DUMP_CNT_WIDTH, default 32, width of the dump counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, scheduler enable.
REQ-007 SHALL have port acc_len, input, ACC_LEN_WIDTH, frames per accumulation.
REQ-008 SHALL have port sync_in, input, 1, frame-start marker, coincident with channel 0 sample.
REQ-009 SHALL have port din_valid, input, 1, datapath input sample strobe.
REQ-010 SHALL have port new_acc, output, 1, registered accumulation-restart pulse to the correlation datapath.
REQ-011 SHALL have port chan_idx, output, log2(VECTOR_LEN), registered channel index of the sample accepted one cycle earlier.
REQ-012 SHALL have port corr_valid, input, 1, correlation-result strobe from the datapath.
REQ-013 SHALL have port out_last, output, 1, registered; marks the last channel of a dumped vector.
REQ-014 SHALL have port dump_cnt, output, DUMP_CNT_WIDTH, completed dumps.
REQ-015 SHALL have port err_sync, output, 1, sticky misaligned-sync flag.
REQ-016 SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, WAIT_SYNC, RUN.
REQ-018 IDLE: chan/frame counters held at 0; en=1 -> WAIT_SYNC, clearing err_sync.
REQ-019 WAIT_SYNC: sync_in&din_valid -> RUN; that sample is channel 0 of frame 0; acc_len latched; new_acc asserted next cycle.
REQ-020 WAIT_SYNC: sync_in without din_valid SHALL be ignored; din_valid without sync_in SHALL not be counted.
REQ-021 RUN: each din_valid increments chan_cnt modulo VECTOR_LEN; wrap VECTOR_LEN-1 -> 0 increments frame_cnt.
REQ-022 RUN: at wrap with frame_cnt = latched_len-1, frame_cnt -> 0, acc_len re-latched, and the next accepted sample (channel 0) SHALL produce new_acc one cycle later.
REQ-023 Latched acc_len of 0 SHALL be treated as 1 (new_acc every frame).
REQ-024 new_acc and chan_idx SHALL have exactly 1-cycle latency from the accepting din_valid cycle, matching the datapath input register stage; new_acc pulse width 1 cycle.
REQ-025 RUN: sync_in&din_valid with chan_cnt != 0 SHALL set err_sync, treat the sample as channel 0 of frame 0 and pulse new_acc (partial accumulation discarded).
REQ-026 RUN: sync_in&din_valid with chan_cnt = 0 SHALL be a no-op beyond normal counting.
REQ-027 en=0 in any state SHALL force IDLE next cycle; no new_acc is issued from that cycle on.
REQ-028 Output side: out_chan counter increments on corr_valid modulo VECTOR_LEN, independent of state; out_last = registered (corr_valid & out_chan = VECTOR_LEN-1).
REQ-029 dump_cnt SHALL increment on each out_last and saturate at all-ones.
REQ-030 busy SHALL be registered state != IDLE.

Reset
REQ-031 rst SHALL force IDLE and zero all counters, new_acc, chan_idx, out_last, dump_cnt, err_sync, busy; rst mid-RUN SHALL abandon the frame with no new_acc.

Structure
REQ-032 State encoding and VECTOR_LEN default SHALL reside in shared package uesprit_pkg.
REQ-033 One sub-module, wrap_counter (modulo-N counter with enable, clear, wrap flag), SHALL be instantiated for chan_cnt and out_chan.

Verification (VECTOR_LEN=4)
REQ-034 acc_len=3, en=1, continuous din_valid, sync on first sample -> new_acc at cycles 1, 13, 25 after sync; chan_idx cycles 0,1,2,3.
REQ-035 acc_len=0 -> new_acc every 4 accepted samples.
REQ-036 sync_in at chan_cnt=2 in RUN -> err_sync=1, new_acc 1 cycle later, chan_idx restarts 0; err_sync persists until en toggles 0->1.
REQ-037 din_valid with gaps (1 of 3 cycles), acc_len=2 -> new_acc every 8 accepted samples, never on an idle cycle.
REQ-038 12 corr_valid pulses -> out_last 3 times, dump_cnt=3; rst asserted mid-frame -> all outputs 0 next cycle, state IDLE.
REQ-039 en dropped mid-accumulation -> busy=0 after 1 cycle, no new_acc until next sync in WAIT_SYNC.
